// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: ID-stage hazard inputs, data-memory handshake,
// and per-stage hold/bubble controls plus debug counters.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ifid_rs1_i;
  logic [4:0]       ifid_rs2_i;
  logic             idex_memread_i;
  logic [4:0]       idex_rd_i;
  logic             branch_taken_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             mem_start_o;
  logic             pc_hold_o;
  logic             ifid_hold_o;
  logic             idex_hold_o;
  logic             exmem_hold_o;
  logic             ifid_bubble_o;
  logic             idex_bubble_o;
  logic             memwb_bubble_o;
  logic             mem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  // Pipeline side: supplies hazard/handshake inputs, consumes controls
  modport master (
    output ifid_rs1_i, ifid_rs2_i, idex_memread_i, idex_rd_i,
           branch_taken_i, mem_req_i, mem_ack_i,
    input  mem_start_o, pc_hold_o, ifid_hold_o, idex_hold_o, exmem_hold_o,
           ifid_bubble_o, idex_bubble_o, memwb_bubble_o, mem_timeout_o,
           stall_cnt_o, flush_cnt_o
  );

  // Controller side
  modport slave (
    input  ifid_rs1_i, ifid_rs2_i, idex_memread_i, idex_rd_i,
           branch_taken_i, mem_req_i, mem_ack_i,
    output mem_start_o, pc_hold_o, ifid_hold_o, idex_hold_o, exmem_hold_o,
           ifid_bubble_o, idex_bubble_o, memwb_bubble_o, mem_timeout_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. A memory stall freezes
// everything up to EX/MEM and bubbles MEM/WB; otherwise load-use hazards
// stall one cycle and taken branches flush IF/ID. Hold/bubble controls are
// combinational; state, wait counter, timeout flag and counters are flops.
module pipeline_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input logic                 clk_i,
  input logic                 rst_i,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    RUN,
    MEM_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mstall;
  logic lu;
  logic br_flush;
  logic mem_start;
  logic pc_hold, ifid_hold, idex_hold, exmem_hold;
  logic ifid_bubble, idex_bubble, memwb_bubble;

  // Hazard priority (memory > load-use > branch), handshake sequencing,
  // and next-state for the wait counter, timeout flag and event counters
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    mstall       = 1'b0;
    lu           = 1'b0;
    br_flush     = 1'b0;
    mem_start    = 1'b0;
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    idex_hold    = 1'b0;
    exmem_hold   = 1'b0;
    ifid_bubble  = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;

    if (rst_i) begin
      ifid_bubble  = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (hz.mem_req_i) begin
            mstall     = 1'b1;
            mem_start  = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = '0;
          end
        end
        MEM_WAIT: begin
          if (!hz.mem_ack_i) begin
            mstall = 1'b1;
            if (wait_cnt_q != WAIT_W'(TIMEOUT)) begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
            if (wait_cnt_d == WAIT_W'(TIMEOUT)) begin
              timeout_d = 1'b1;
            end
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase

      lu = !mstall && hz.idex_memread_i && (hz.idex_rd_i != 5'd0) &&
           ((hz.idex_rd_i == hz.ifid_rs1_i) || (hz.idex_rd_i == hz.ifid_rs2_i));
      br_flush = !mstall && !lu && hz.branch_taken_i;

      pc_hold      = mstall || lu;
      ifid_hold    = mstall || lu;
      idex_hold    = mstall;
      exmem_hold   = mstall;
      memwb_bubble = mstall;
      idex_bubble  = lu;
      ifid_bubble  = br_flush;

      if (pc_hold && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (br_flush && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // Registered FSM state, wait counter, sticky timeout and event counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.mem_start_o    = mem_start;
  assign hz.pc_hold_o      = pc_hold;
  assign hz.ifid_hold_o    = ifid_hold;
  assign hz.idex_hold_o    = idex_hold;
  assign hz.exmem_hold_o   = exmem_hold;
  assign hz.ifid_bubble_o  = ifid_bubble;
  assign hz.idex_bubble_o  = idex_bubble;
  assign hz.memwb_bubble_o = memwb_bubble;
  assign hz.mem_timeout_o  = timeout_q;
  assign hz.stall_cnt_o    = stall_cnt_q;
  assign hz.flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl, built with a small
// counter width and short timeout so saturation and timeout are reachable.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .hz   (hz)
  );

  // {pc, ifid, idex, exmem} holds and {ifid, idex, memwb} bubbles
  logic [3:0] holds;
  logic [2:0] bubbles;
  assign holds   = {hz.pc_hold_o, hz.ifid_hold_o, hz.idex_hold_o, hz.exmem_hold_o};
  assign bubbles = {hz.ifid_bubble_o, hz.idex_bubble_o, hz.memwb_bubble_o};

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs;
    hz.ifid_rs1_i     = 5'd0;
    hz.ifid_rs2_i     = 5'd0;
    hz.idex_memread_i = 1'b0;
    hz.idex_rd_i      = 5'd0;
    hz.branch_taken_i = 1'b0;
    hz.mem_req_i      = 1'b0;
    hz.mem_ack_i      = 1'b0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    hz.mem_req_i      = 1'b1;
    hz.branch_taken_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (hz.mem_start_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_start cycle %0d got %b expected 0", i, hz.mem_start_o); end
      checks++; if (holds !== 4'b0000) begin errors++; $display("[TB] FAIL reset_holds cycle %0d got %b expected 0000", i, holds); end
      checks++; if (bubbles !== 3'b111) begin errors++; $display("[TB] FAIL reset_bubbles cycle %0d got %b expected 111", i, bubbles); end
    end
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    checks++; if (hz.stall_cnt_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_stall_cnt got %0d expected 0", hz.stall_cnt_o); end
    checks++; if (hz.flush_cnt_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_flush_cnt got %0d expected 0", hz.flush_cnt_o); end
    checks++; if (hz.mem_timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %b expected 0", hz.mem_timeout_o); end
    @(negedge clk);
    checks++; if ({holds, bubbles} !== 7'b0) begin errors++; $display("[TB] FAIL idle_controls got %b expected 0000000", {holds, bubbles}); end
  endtask

  task automatic test_load_use;
    do_reset();
    hz.idex_memread_i = 1'b1;
    hz.idex_rd_i      = 5'd5;
    hz.ifid_rs1_i     = 5'd1;
    hz.ifid_rs2_i     = 5'd5;
    @(negedge clk);
    checks++; if (holds !== 4'b1100) begin errors++; $display("[TB] FAIL lu_holds got %b expected 1100", holds); end
    checks++; if (bubbles !== 3'b010) begin errors++; $display("[TB] FAIL lu_bubbles got %b expected 010", bubbles); end
    next_cycle();
    hz.idex_memread_i = 1'b0;
    @(negedge clk);
    checks++; if (holds !== 4'b0000) begin errors++; $display("[TB] FAIL lu_release got %b expected 0000", holds); end
    checks++; if (hz.stall_cnt_o !== 3'd1) begin errors++; $display("[TB] FAIL lu_stall_cnt got %0d expected 1", hz.stall_cnt_o); end
    next_cycle();
    // rd = x0 never creates a dependency even when sources are x0
    hz.idex_memread_i = 1'b1;
    hz.idex_rd_i      = 5'd0;
    hz.ifid_rs1_i     = 5'd0;
    hz.ifid_rs2_i     = 5'd0;
    @(negedge clk);
    checks++; if ({holds, bubbles} !== 7'b0) begin errors++; $display("[TB] FAIL lu_rd0 got %b expected 0000000", {holds, bubbles}); end
    next_cycle();
    clear_inputs();
    checks++; if (hz.stall_cnt_o !== 3'd1) begin errors++; $display("[TB] FAIL lu_rd0_stall_cnt got %0d expected 1", hz.stall_cnt_o); end
  endtask

  task automatic test_branch;
    do_reset();
    hz.branch_taken_i = 1'b1;
    @(negedge clk);
    checks++; if ({holds, bubbles} !== 7'b0000_100) begin errors++; $display("[TB] FAIL br_controls got %b expected 0000100", {holds, bubbles}); end
    next_cycle();
    checks++; if (hz.flush_cnt_o !== 3'd1) begin errors++; $display("[TB] FAIL br_flush_cnt got %0d expected 1", hz.flush_cnt_o); end
    // Branch coinciding with a load-use hit is dropped
    hz.idex_memread_i = 1'b1;
    hz.idex_rd_i      = 5'd7;
    hz.ifid_rs1_i     = 5'd7;
    @(negedge clk);
    checks++; if ({holds, bubbles} !== 7'b1100_010) begin errors++; $display("[TB] FAIL br_lu_controls got %b expected 1100010", {holds, bubbles}); end
    next_cycle();
    clear_inputs();
    checks++; if (hz.flush_cnt_o !== 3'd1) begin errors++; $display("[TB] FAIL br_lu_flush_cnt got %0d expected 1", hz.flush_cnt_o); end
    checks++; if (hz.stall_cnt_o !== 3'd1) begin errors++; $display("[TB] FAIL br_lu_stall_cnt got %0d expected 1", hz.stall_cnt_o); end
  endtask

  task automatic test_mem_handshake;
    do_reset();
    hz.mem_req_i = 1'b1;
    @(negedge clk);
    checks++; if (hz.mem_start_o !== 1'b1) begin errors++; $display("[TB] FAIL mem_issue_start got %b expected 1", hz.mem_start_o); end
    checks++; if ({holds, bubbles} !== 7'b1111_001) begin errors++; $display("[TB] FAIL mem_issue_controls got %b expected 1111001", {holds, bubbles}); end
    // Request stays high while waiting; no second start may appear
    for (int i = 1; i <= 2; i++) begin
      next_cycle();
      hz.branch_taken_i = 1'b1;
      @(negedge clk);
      checks++; if (hz.mem_start_o !== 1'b0) begin errors++; $display("[TB] FAIL mem_wait%0d_start got %b expected 0", i, hz.mem_start_o); end
      checks++; if ({holds, bubbles} !== 7'b1111_001) begin errors++; $display("[TB] FAIL mem_wait%0d_controls got %b expected 1111001", i, {holds, bubbles}); end
    end
    next_cycle();
    hz.mem_req_i      = 1'b0;
    hz.branch_taken_i = 1'b0;
    hz.mem_ack_i      = 1'b1;
    @(negedge clk);
    checks++; if ({holds, bubbles} !== 7'b0) begin errors++; $display("[TB] FAIL mem_ack_release got %b expected 0000000", {holds, bubbles}); end
    next_cycle();
    checks++; if (hz.stall_cnt_o !== 3'd3) begin errors++; $display("[TB] FAIL mem_stall_cnt got %0d expected 3", hz.stall_cnt_o); end
    checks++; if (hz.flush_cnt_o !== 3'd0) begin errors++; $display("[TB] FAIL mem_flush_cnt got %0d expected 0", hz.flush_cnt_o); end
    // Ack seen in RUN has no effect
    @(negedge clk);
    checks++; if ({holds, hz.mem_start_o} !== 5'b0) begin errors++; $display("[TB] FAIL mem_ack_in_run got %b expected 00000", {holds, hz.mem_start_o}); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_back_to_back;
    do_reset();
    hz.mem_req_i = 1'b1;
    @(negedge clk);
    checks++; if (hz.mem_start_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_start1 got %b expected 1", hz.mem_start_o); end
    next_cycle();
    hz.mem_ack_i = 1'b1;
    @(negedge clk);
    checks++; if ({hz.mem_start_o, hz.pc_hold_o} !== 2'b00) begin errors++; $display("[TB] FAIL b2b_ack1 got %b expected 00", {hz.mem_start_o, hz.pc_hold_o}); end
    next_cycle();
    hz.mem_ack_i = 1'b0;
    @(negedge clk);
    checks++; if ({hz.mem_start_o, hz.pc_hold_o} !== 2'b11) begin errors++; $display("[TB] FAIL b2b_start2 got %b expected 11", {hz.mem_start_o, hz.pc_hold_o}); end
    next_cycle();
    hz.mem_req_i = 1'b0;
    hz.mem_ack_i = 1'b1;
    @(negedge clk);
    checks++; if (hz.pc_hold_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ack2 got %b expected 0", hz.pc_hold_o); end
    next_cycle();
    clear_inputs();
    checks++; if (hz.stall_cnt_o !== 3'd2) begin errors++; $display("[TB] FAIL b2b_stall_cnt got %0d expected 2", hz.stall_cnt_o); end
  endtask

  task automatic test_timeout;
    do_reset();
    hz.mem_req_i = 1'b1;
    next_cycle();
    hz.mem_req_i = 1'b0;
    for (int i = 1; i <= TIMEOUT + 2; i++) begin
      next_cycle();
      checks++; if (hz.mem_timeout_o !== ((i >= TIMEOUT) ? 1'b1 : 1'b0)) begin errors++; $display("[TB] FAIL timeout_after_wait%0d got %b expected %b", i, hz.mem_timeout_o, (i >= TIMEOUT) ? 1'b1 : 1'b0); end
    end
    @(negedge clk);
    checks++; if (holds !== 4'b1111) begin errors++; $display("[TB] FAIL timeout_still_stalled got %b expected 1111", holds); end
    // Reset abandons the outstanding access
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({holds, hz.mem_start_o, bubbles} !== 8'b0000_0_111) begin errors++; $display("[TB] FAIL abort_in_reset got %b expected 00000111", {holds, hz.mem_start_o, bubbles}); end
    next_cycle();
    rst = 1'b0;
    checks++; if (hz.mem_timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_timeout got %b expected 0", hz.mem_timeout_o); end
    @(negedge clk);
    checks++; if ({holds, hz.mem_start_o, bubbles} !== 8'b0) begin errors++; $display("[TB] FAIL abort_run got %b expected 00000000", {holds, hz.mem_start_o, bubbles}); end
    next_cycle();
  endtask

  task automatic test_saturation;
    int exp_cnt;
    do_reset();
    hz.idex_memread_i = 1'b1;
    hz.idex_rd_i      = 5'd3;
    hz.ifid_rs1_i     = 5'd3;
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      exp_cnt = (i > 7) ? 7 : i;
      checks++; if (hz.stall_cnt_o !== 3'(exp_cnt)) begin errors++; $display("[TB] FAIL sat_stall_cnt cycle %0d got %0d expected %0d", i, hz.stall_cnt_o, exp_cnt); end
    end
    clear_inputs();
  endtask

  // Test sequence
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_handshake();
    test_back_to_back();
    test_timeout();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
